// File: rtl/pipe_stage_fifo.sv
// pipe_stage_fifo: elastic inter-stage pipeline register.
// Carries an opaque PAYLOAD_W-bit stage bundle through a DEPTH-entry circular
// FIFO with a valid/ready handshake on both sides and a synchronous flush.
// When empty it presents NOP_VALUE, so downstream stages see ordinary bubbles.
//
// Ports:
//   clk_in         clock, rising edge
//   rst_in         asynchronous active-low reset
//   flush_in       synchronous flush, discards all entries
//   valid_in       upstream payload valid
//   data_in        upstream payload
//   ready_out      stage can accept a payload (registered state only)
//   valid_out      head entry valid toward downstream
//   data_out       head payload, NOP_VALUE when valid_out=0
//   ready_in       downstream accepts head entry
//   count_out      current occupancy
//   stall_cnt_out  cycles with valid_out=1 and ready_in=0 (stats build only)
//   bubble_cnt_out cycles with valid_out=0 and ready_in=1 (stats build only)
//
// Optional feature macro: PIPE_STAGE_FIFO_STATS_EN enables the saturating
// stall/bubble counters; otherwise both stat ports are tied to zero.
module pipe_stage_fifo #(
    parameter int unsigned           PAYLOAD_W = 109,
    parameter int unsigned           DEPTH     = 2,
    parameter logic [PAYLOAD_W-1:0]  NOP_VALUE = '0,
    parameter int unsigned           STAT_W    = 16
) (
    input  logic                         clk_in,
    input  logic                         rst_in,
    input  logic                         flush_in,
    input  logic                         valid_in,
    input  logic [PAYLOAD_W-1:0]         data_in,
    output logic                         ready_out,
    output logic                         valid_out,
    output logic [PAYLOAD_W-1:0]         data_out,
    input  logic                         ready_in,
    output logic [$clog2(DEPTH+1)-1:0]   count_out,
    output logic [STAT_W-1:0]            stall_cnt_out,
    output logic [STAT_W-1:0]            bubble_cnt_out
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [PAYLOAD_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]     rd_ptr;
    logic [PTR_W-1:0]     wr_ptr;
    logic [CNT_W-1:0]     count;

    logic                 push;
    logic                 pop;
    logic [PTR_W-1:0]     rd_ptr_nxt;
    logic [PTR_W-1:0]     wr_ptr_nxt;
    logic [CNT_W-1:0]     count_nxt;

    // Handshake flags come from registered occupancy only.
    assign ready_out = (count != CNT_W'(DEPTH));
    assign valid_out = (count != '0);
    assign data_out  = valid_out ? mem[rd_ptr] : NOP_VALUE;
    assign count_out = count;

    assign push = valid_in & ready_out;
    assign pop  = valid_out & ready_in;

    // Next-state for pointers and occupancy; wrap by explicit compare so
    // non-power-of-two depths work.
    always_comb begin
        rd_ptr_nxt = rd_ptr;
        wr_ptr_nxt = wr_ptr;
        count_nxt  = count;
        if (push) begin
            wr_ptr_nxt = (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_nxt = (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
        end
        if (push && !pop) begin
            count_nxt = count + CNT_W'(1);
        end else if (pop && !push) begin
            count_nxt = count - CNT_W'(1);
        end
    end

    // Control state: reset > flush > push/pop.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush_in) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            rd_ptr <= rd_ptr_nxt;
            wr_ptr <= wr_ptr_nxt;
            count  <= count_nxt;
        end
    end

    // Storage; flush leaves contents in place since they are unreachable.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= NOP_VALUE;
            end
        end else if (!flush_in && push) begin
            mem[wr_ptr] <= data_in;
        end
    end

`ifdef PIPE_STAGE_FIFO_STATS_EN
    logic [STAT_W-1:0] stall_cnt;
    logic [STAT_W-1:0] bubble_cnt;

    // Saturating counters; only reset clears them, flush does not.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            stall_cnt  <= '0;
            bubble_cnt <= '0;
        end else begin
            if (valid_out && !ready_in && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + STAT_W'(1);
            end
            if (!valid_out && ready_in && (bubble_cnt != '1)) begin
                bubble_cnt <= bubble_cnt + STAT_W'(1);
            end
        end
    end

    assign stall_cnt_out  = stall_cnt;
    assign bubble_cnt_out = bubble_cnt;
`else
    assign stall_cnt_out  = '0;
    assign bubble_cnt_out = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_fifo.sv
// Directed self-checking bench for pipe_stage_fifo at default parameters
// (PAYLOAD_W=109, DEPTH=2, NOP_VALUE=0, STAT_W=16).
module tb_pipe_stage_fifo;

    localparam int unsigned PAYLOAD_W = 109;
    localparam int unsigned DEPTH     = 2;
    localparam int unsigned STAT_W    = 16;
    localparam int unsigned CNT_W     = $clog2(DEPTH + 1);

    logic                 clk_in;
    logic                 rst_in;
    logic                 flush_in;
    logic                 valid_in;
    logic [PAYLOAD_W-1:0] data_in;
    logic                 ready_out;
    logic                 valid_out;
    logic [PAYLOAD_W-1:0] data_out;
    logic                 ready_in;
    logic [CNT_W-1:0]     count_out;
    logic [STAT_W-1:0]    stall_cnt_out;
    logic [STAT_W-1:0]    bubble_cnt_out;

    int unsigned n_tests;
    int unsigned n_fail;

    pipe_stage_fifo #(
        .PAYLOAD_W (PAYLOAD_W),
        .DEPTH     (DEPTH),
        .NOP_VALUE ('0),
        .STAT_W    (STAT_W)
    ) dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .flush_in       (flush_in),
        .valid_in       (valid_in),
        .data_in        (data_in),
        .ready_out      (ready_out),
        .valid_out      (valid_out),
        .data_out       (data_out),
        .ready_in       (ready_in),
        .count_out      (count_out),
        .stall_cnt_out  (stall_cnt_out),
        .bubble_cnt_out (bubble_cnt_out)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic check_state(input string tag, input logic v, input logic [127:0] d,
                               input logic r, input logic [127:0] c);
        check({tag, ".valid"}, 128'(valid_out), 128'(v));
        check({tag, ".data"},  128'(data_out),  d);
        check({tag, ".ready"}, 128'(ready_out), 128'(r));
        check({tag, ".count"}, 128'(count_out), c);
    endtask

    initial begin
        n_tests  = 0;
        n_fail   = 0;
        rst_in   = 1'b0;
        flush_in = 1'b0;
        valid_in = 1'b0;
        data_in  = '0;
        ready_in = 1'b0;

        // Reset then idle
        #3;
        check_state("reset", 1'b0, 128'h0, 1'b1, 128'd0);
        check("reset.stall",  128'(stall_cnt_out),  128'd0);
        check("reset.bubble", 128'(bubble_cnt_out), 128'd0);
        tick();
        rst_in = 1'b1;
        tick();
        tick();
        check_state("idle", 1'b0, 128'h0, 1'b1, 128'd0);

        // Streaming at full throughput
        ready_in = 1'b1;
        valid_in = 1'b1;
        data_in  = PAYLOAD_W'(32'h11);
        tick();
        check_state("stream1", 1'b1, 128'h11, 1'b1, 128'd1);
        data_in = PAYLOAD_W'(32'h22);
        tick();
        check_state("stream2", 1'b1, 128'h22, 1'b1, 128'd1);
        data_in = PAYLOAD_W'(32'h33);
        tick();
        check_state("stream3", 1'b1, 128'h33, 1'b1, 128'd1);
        valid_in = 1'b0;
        tick();
        check_state("stream_drain", 1'b0, 128'h0, 1'b1, 128'd0);

        // Backpressure: fill, ignored push, drain
        ready_in = 1'b0;
        valid_in = 1'b1;
        data_in  = PAYLOAD_W'(32'hA);
        tick();
        check_state("bp_a", 1'b1, 128'hA, 1'b1, 128'd1);
        data_in = PAYLOAD_W'(32'hB);
        tick();
        check_state("bp_full", 1'b1, 128'hA, 1'b0, 128'd2);
        data_in = PAYLOAD_W'(32'hC);
        tick();
        check_state("bp_ignored", 1'b1, 128'hA, 1'b0, 128'd2);
        ready_in = 1'b1;
        tick();
        check_state("bp_pop_a", 1'b1, 128'hB, 1'b1, 128'd1);
        tick();
        check_state("bp_pop_b", 1'b1, 128'hC, 1'b1, 128'd1);
        valid_in = 1'b0;
        tick();
        check_state("bp_drain", 1'b0, 128'h0, 1'b1, 128'd0);

        // Simultaneous push/pop at count=1, pointers wrap repeatedly
        ready_in = 1'b0;
        valid_in = 1'b1;
        data_in  = PAYLOAD_W'(32'h5);
        tick();
        check_state("pp_head", 1'b1, 128'h5, 1'b1, 128'd1);
        ready_in = 1'b1;
        for (int i = 0; i < 10; i++) begin
            data_in = PAYLOAD_W'(32'h6 + 32'(i));
            tick();
            check("pp.count", 128'(count_out), 128'd1);
            check("pp.data",  128'(data_out),  128'(32'h6 + 32'(i)));
        end
        valid_in = 1'b0;
        tick();
        check_state("pp_drain", 1'b0, 128'h0, 1'b1, 128'd0);

        // Flush with count=2 and concurrent push/pop
        ready_in = 1'b0;
        valid_in = 1'b1;
        data_in  = PAYLOAD_W'(32'h1);
        tick();
        data_in = PAYLOAD_W'(32'h2);
        tick();
        check("fl.count_pre", 128'(count_out), 128'd2);
        data_in  = PAYLOAD_W'(32'h7);
        flush_in = 1'b1;
        ready_in = 1'b1;
        tick();
        check_state("flush_full", 1'b0, 128'h0, 1'b1, 128'd0);
        flush_in = 1'b0;
        valid_in = 1'b0;
        tick();
        check_state("flush_after", 1'b0, 128'h0, 1'b1, 128'd0);

        // Flush at count=1 with a push that would have been accepted
        ready_in = 1'b0;
        valid_in = 1'b1;
        data_in  = PAYLOAD_W'(32'h8);
        tick();
        data_in  = PAYLOAD_W'(32'h9);
        flush_in = 1'b1;
        tick();
        flush_in = 1'b0;
        valid_in = 1'b0;
        check_state("flush_one", 1'b0, 128'h0, 1'b1, 128'd0);
        tick();
        check_state("flush_one_after", 1'b0, 128'h0, 1'b1, 128'd0);

        // Asynchronous reset mid-transfer
        valid_in = 1'b1;
        data_in  = PAYLOAD_W'(32'h44);
        tick();
        check("rst_mid.count_pre", 128'(count_out), 128'd1);
        #2;
        rst_in = 1'b0;
        #1;
        check_state("rst_mid", 1'b0, 128'h0, 1'b1, 128'd0);
        check("rst_mid.stall",  128'(stall_cnt_out),  128'd0);
        check("rst_mid.bubble", 128'(bubble_cnt_out), 128'd0);
        valid_in = 1'b0;
        ready_in = 1'b0;
        tick();
        rst_in = 1'b1;
        tick();

        // Statistics: 5 stall cycles, 1 pop, 3 bubble cycles
        valid_in = 1'b1;
        data_in  = PAYLOAD_W'(32'h55);
        tick();
        valid_in = 1'b0;
        repeat (5) tick();
        ready_in = 1'b1;
        tick();
        repeat (3) tick();
        ready_in = 1'b0;
`ifdef PIPE_STAGE_FIFO_STATS_EN
        check("stats.stall",  128'(stall_cnt_out),  128'd5);
        check("stats.bubble", 128'(bubble_cnt_out), 128'd3);
`else
        check("stats.stall",  128'(stall_cnt_out),  128'd0);
        check("stats.bubble", 128'(bubble_cnt_out), 128'd0);
`endif
        // Flush must not clear the counters
        flush_in = 1'b1;
        tick();
        flush_in = 1'b0;
`ifdef PIPE_STAGE_FIFO_STATS_EN
        check("stats.flush_stall",  128'(stall_cnt_out),  128'd5);
        check("stats.flush_bubble", 128'(bubble_cnt_out), 128'd3);
`else
        check("stats.flush_stall",  128'(stall_cnt_out),  128'd0);
        check("stats.flush_bubble", 128'(bubble_cnt_out), 128'd0);
`endif
        #2;
        rst_in = 1'b0;
        #1;
        check("stats.rst_stall",  128'(stall_cnt_out),  128'd0);
        check("stats.rst_bubble", 128'(bubble_cnt_out), 128'd0);
        tick();
        rst_in = 1'b1;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_stage_fifo.md
Name: pipe_stage_fifo

Overview:
- Parametrised, elastic successor to the fixed-field inter-stage pipeline registers (ID/EX, EX/MEM, MEM/WB).
- Carries an opaque PAYLOAD_W-bit bundle (instIdx, addresses, store value, rd fields, packed by the instantiating stage) through a DEPTH-entry skid FIFO.
- Replaces the global stall vector with a per-stage valid/ready handshake and a flush input.
- Emits a NOP payload whenever empty, so downstream stages see bubbles exactly as they do today.

Parameters:
- PAYLOAD_W, 109, width of the packed stage payload in bits.
- DEPTH, 2, number of entries; legal range 1..8. DEPTH=1 gives half throughput, DEPTH>=2 gives full throughput.
- NOP_VALUE, 0 (PAYLOAD_W bits), payload driven when empty; encodes idNOP/regNOP/writeDisable.
- STAT_W, 16, width of the statistics counters (optional feature only).

Ports:
- clk_in  input  1  clock; all state updates on the rising edge.
- rst_in  input  1  asynchronous, active-low reset.
- flush_in  input  1  synchronous flush (branch mispredict / exception); discards all entries.
- valid_in  input  1  upstream payload valid.
- data_in  input  PAYLOAD_W  upstream payload.
- ready_out  output  1  stage can accept a payload this cycle.
- valid_out  output  1  head entry valid toward the downstream stage.
- data_out  output  PAYLOAD_W  head entry payload, or NOP_VALUE when valid_out=0.
- ready_in  input  1  downstream accepts the head entry this cycle.
- count_out  output  $clog2(DEPTH+1)  current occupancy.
- stall_cnt_out  output  STAT_W  cycles with valid_out=1 and ready_in=0 (optional feature).
- bubble_cnt_out  output  STAT_W  cycles with valid_out=0 and ready_in=1 (optional feature).

Behaviour:
- Storage:
  - DEPTH-entry circular buffer with rd_ptr, wr_ptr and count (0..DEPTH).
  - Pointers wrap from DEPTH-1 to 0. DEPTH need not be a power of 2; wrap uses explicit compare.
- Handshake signals:
  - ready_out = (count != DEPTH). It depends on registered state only; there is no combinational path from ready_in.
  - valid_out = (count != 0).
  - data_out = mem[rd_ptr] when valid_out=1, else NOP_VALUE.
  - push = valid_in & ready_out; pop = valid_out & ready_in.
- Latency:
  - A payload pushed in cycle N is visible at data_out in cycle N+1 at the earliest.
  - No same-cycle bypass.
  - Ordering is strictly FIFO.
- Count update:
  - push only: count+1.
  - pop only: count-1.
  - push and pop together: count unchanged, both pointers advance.
- Full: ready_out=0, so valid_in is ignored and the upstream must hold its payload.
- Empty: pop is impossible, and ready_in has no effect except on the bubble statistics.
- Priority order: reset > flush > push/pop.
- flush_in=1 at a rising edge:
  - count, rd_ptr and wr_ptr go to 0.
  - Any push or pop in that cycle is discarded.
  - Next cycle: valid_out=0, data_out=NOP_VALUE, ready_out=1.
  - Storage contents need not be cleared.
- Reset (rst_in=0, asynchronous):
  - Immediately: count=0, pointers=0, all entries=NOP_VALUE.
  - Outputs: valid_out=0, data_out=NOP_VALUE, ready_out=1, count_out=0, stats=0.
  - Reset asserted mid-transfer discards all entries.
  - Deassertion is synchronised by the instantiating top.
- No X may propagate to data_out while valid_out=0.

Optional Feature:
- PIPE_STAGE_FIFO_STATS_EN defined:
  - stall_cnt_out and bubble_cnt_out increment on their conditions each cycle.
  - Both saturate at all-ones.
  - Cleared by reset only; flush_in does not clear them.
- Undefined: both ports exist but are tied to 0, and no counter flops are inferred.

Test Plan:
- Reset then idle (DEPTH=2) -> valid_out=0, data_out=NOP_VALUE, ready_out=1, count_out=0.
- Stream: push 0x11, 0x22, 0x33 on consecutive cycles, ready_in=1 throughout -> data_out shows 0x11, 0x22, 0x33 in cycles 1, 2, 3. count_out stays 1 and ready_out stays 1 (full throughput).
- Backpressure: ready_in=0, push 0xA, 0xB -> count_out=2, ready_out=0. A third push of 0xC is ignored. Raise ready_in -> 0xA then 0xB appear, and 0xC is accepted only after ready_out returns to 1.
- Simultaneous push/pop at count=1 with head 0x5, pushing 0x6 -> count_out stays 1, next data_out=0x6. Repeat 10 times so the pointers wrap.
- Flush with count=2 and a concurrent push of 0x7 -> next cycle count_out=0, valid_out=0, data_out=NOP_VALUE. 0x7 never appears.
- With PIPE_STAGE_FIFO_STATS_EN: 5 cycles of valid_out=1/ready_in=0, then 3 cycles of empty/ready_in=1 -> stall_cnt_out=5, bubble_cnt_out=3. Assert rst_in=0 mid-sequence -> both counters read 0 immediately.
